// File: rtl/pc_next_unit_pkg.sv
// Shared control encodings for the fetch/PC path.
// Holds the PC-unit FSM state encoding, the default reset PC and the
// branch-type codes used to steer next-PC selection.
package pc_next_unit_pkg;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } pc_state_t;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

    // Redirect class, listed lowest to highest priority.
    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_COND = 2'd1,
        BR_JUMP = 2'd2,
        BR_JREG = 2'd3
    } br_type_t;

    // J-type target: keep the 256 MB region of the link address.
    function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                                input logic [25:0] index);
        return {pc_plus4[31:28], index, 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_mux.sv
// Combinational next-PC selection.
// Ports:
//   pc_plus4      - sequential successor / link value
//   branch_taken  - conditional branch resolved taken
//   branch_offset - sign-extended word offset (unshifted)
//   jump          - J/JAL request, jump_index its 26-bit index
//   jump_reg      - JR/JALR request, reg_target its target
//   next_pc       - selected next PC
module next_pc_mux
    import pc_next_unit_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jump_reg,
    input  logic [31:0] reg_target,
    output logic [31:0] next_pc
);

    br_type_t w_sel;

    always_comb begin
        w_sel = BR_NONE;
        if (jump_reg)          w_sel = BR_JREG;
        else if (jump)         w_sel = BR_JUMP;
        else if (branch_taken) w_sel = BR_COND;
    end

    always_comb begin
        next_pc = pc_plus4;
        case (w_sel)
            BR_JREG: next_pc = reg_target;
            BR_JUMP: next_pc = jump_target(pc_plus4, jump_index);
            // Word offset to byte offset; top bits drop, sum wraps mod 2^32.
            BR_COND: next_pc = pc_plus4 + {branch_offset[29:0], 2'b00};
            default: next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/pc_next_unit.sv
// Program counter and fetch sequencing for a non-pipelined core.
// Each instruction is fetched (S_FETCH, waits on imem_ready) then held in
// S_EXEC until stall drops, at which point redirects are sampled and pc
// moves. A misaligned jump-register target halts the unit until reset.
// Ports:
//   clk, rst                - clock, synchronous active-high reset
//   stall                   - hold current instruction in S_EXEC
//   branch_taken/offset     - conditional branch redirect
//   jump/jump_index         - J-type redirect
//   jump_reg/reg_target     - register redirect
//   imem_req/addr/ready     - instruction fetch handshake
//   instr_valid             - instruction at pc is executing
//   pc, pc_plus4            - current PC and link value
//   misaligned              - sticky jump-register alignment fault
module pc_next_unit
    import pc_next_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = PC_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jump_reg,
    input  logic [31:0] reg_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        misaligned
);

    pc_state_t   r_state;
    pc_state_t   w_next_state;
    logic [31:0] r_pc;
    logic        r_misaligned;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_next_pc;
    logic        w_retire;
    logic        w_fault;
    logic        w_pc_load;

    assign w_pc_plus4 = r_pc + 32'd4;
    // Redirects only count on the cycle the instruction retires.
    assign w_retire   = (r_state == S_EXEC) && !stall;
    assign w_fault    = w_retire && jump_reg && (reg_target[1:0] != 2'b00);

    next_pc_mux u_next_pc_mux (
        .pc_plus4      (w_pc_plus4),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_index    (jump_index),
        .jump_reg      (jump_reg),
        .reg_target    (reg_target),
        .next_pc       (w_next_pc)
    );

    always_comb begin
        w_next_state = r_state;
        w_pc_load    = 1'b0;
        case (r_state)
            S_RESET: w_next_state = S_FETCH;
            S_FETCH: if (imem_ready) w_next_state = S_EXEC;
            S_EXEC: begin
                if (w_fault) begin
                    w_next_state = S_HALT;
                end else if (w_retire) begin
                    w_next_state = S_FETCH;
                    w_pc_load    = 1'b1;
                end
            end
            default: w_next_state = S_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_RESET;
            r_pc         <= RESET_PC;
            r_misaligned <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_pc_load) r_pc <= w_next_pc;
            if (w_fault)   r_misaligned <= 1'b1;
        end
    end

    assign imem_req    = (r_state == S_FETCH);
    assign imem_addr   = r_pc;
    assign instr_valid = (r_state == S_EXEC);
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign misaligned  = r_misaligned;

endmodule

// File: tb/tb_pc_next_unit.sv
module tb_pc_next_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        jump_reg;
    logic [31:0] reg_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misaligned;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: instruction-level view. m_phase 0=after reset, 1=fetching,
    // 2=executing, 3=halted.
    int          m_phase;
    logic [31:0] m_pc;
    logic        m_mis;

    pc_next_unit #(.RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_index    (jump_index),
        .jump_reg      (jump_reg),
        .reg_target    (reg_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .instr_valid   (instr_valid),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .misaligned    (misaligned)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_target();
        logic [31:0] seq;
        seq = m_pc + 32'd4;
        if (jump_reg)     return reg_target;
        if (jump)         return (seq & 32'hF000_0000) | ({6'b0, jump_index} * 32'd4);
        if (branch_taken) return seq + branch_offset * 32'd4;
        return seq;
    endfunction

    task automatic step();
        if (rst) begin
            m_phase = 0; m_pc = RST_PC; m_mis = 1'b0;
        end else begin
            case (m_phase)
                0: m_phase = 1;
                1: if (imem_ready) m_phase = 2;
                2: if (!stall) begin
                    if (jump_reg && reg_target[1:0] != 2'b00) begin
                        m_mis = 1'b1; m_phase = 3;
                    end else begin
                        m_pc = ref_target(); m_phase = 1;
                    end
                end
                default: ;
            endcase
        end
        @(posedge clk); #1;
        check("pc", pc, m_pc);
        check("pc_plus4", pc_plus4, m_pc + 32'd4);
        check("imem_addr", imem_addr, m_pc);
        check("imem_req", {31'b0, imem_req}, {31'b0, m_phase == 1});
        check("instr_valid", {31'b0, instr_valid}, {31'b0, m_phase == 2});
        check("misaligned", {31'b0, misaligned}, {31'b0, m_mis});
    endtask

    task automatic idle_inputs();
        stall = 0; branch_taken = 0; branch_offset = 0; jump = 0;
        jump_index = 0; jump_reg = 0; reg_target = 0; imem_ready = 1;
    endtask

    task automatic go_exec();
        for (int i = 0; i < 10 && m_phase != 2; i++) step();
        if (m_phase != 2) check("reach_exec", {31'b0, instr_valid}, 32'd1);
    endtask

    task automatic exec_with(input logic bt, input logic [31:0] bo, input logic j,
                             input logic [25:0] ji, input logic jr, input logic [31:0] rt);
        go_exec();
        branch_taken = bt; branch_offset = bo; jump = j; jump_index = ji;
        jump_reg = jr; reg_target = rt;
        step();
        idle_inputs();
    endtask

    task automatic set_pc(input logic [31:0] a);
        exec_with(0, 0, 0, 0, 1, a);
    endtask

    initial begin
        idle_inputs();
        rst = 1; m_phase = 0; m_pc = RST_PC; m_mis = 0;
        repeat (3) step();
        check("rst_pc", pc, RST_PC);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        rst = 0;
        step();
        check("first_req", {31'b0, imem_req}, 32'd1);
        // Sequential fetch: pc 0 -> 4 -> 8, two cycles per instruction
        repeat (4) step();
        check("seq_pc8", pc, 32'h0000_0008);

        // Branch backwards, then jump overriding branch
        set_pc(32'h0000_0100);
        exec_with(1, 32'hFFFF_FFFE, 0, 0, 0, 0);
        check("br_back", pc, 32'h0000_00FC);
        set_pc(32'h0000_0100);
        exec_with(1, 32'hFFFF_FFFE, 1, 26'h0000040, 0, 0);
        check("jump_wins", pc, 32'h0000_0100);

        // Jump-register priority, then misaligned fault
        set_pc(32'h4000_0010);
        exec_with(0, 0, 1, 26'h0000040, 1, 32'h0000_2000);
        check("jr_wins", pc, 32'h0000_2000);
        set_pc(32'h4000_0010);
        exec_with(0, 0, 1, 26'h0000040, 1, 32'h0000_2002);
        check("fault_mis", {31'b0, misaligned}, 32'd1);
        check("fault_pc", pc, 32'h4000_0010);
        repeat (3) step();
        check("halt_req", {31'b0, imem_req}, 32'd0);
        rst = 1; step(); rst = 0;
        check("mis_clr", {31'b0, misaligned}, 32'd0);
        step();

        // Fetch wait then execute stall
        imem_ready = 0;
        repeat (3) step();
        check("wait_addr", imem_addr, 32'h0000_0000);
        imem_ready = 1;
        step();
        stall = 1;
        repeat (2) step();
        check("stall_valid", {31'b0, instr_valid}, 32'd1);
        stall = 0;
        step();
        check("after_stall", pc, 32'h0000_0004);

        // Reset during execute with a branch pending
        set_pc(32'h0000_0400);
        go_exec();
        branch_taken = 1; branch_offset = 32'd8; rst = 1;
        step();
        rst = 0; idle_inputs();
        check("rst_abort", pc, RST_PC);

        // Wrap at top of address space
        set_pc(32'hFFFF_FFFC);
        check("wrap_plus4", pc_plus4, 32'h0000_0000);
        exec_with(0, 0, 0, 0, 0, 0);
        check("wrap_pc", pc, 32'h0000_0000);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(63) == 0);
            imem_ready    = 1'($urandom_range(1));
            stall         = ($urandom_range(3) == 0);
            branch_taken  = 1'($urandom_range(1));
            branch_offset = $urandom;
            jump          = ($urandom_range(3) == 0);
            jump_index    = 26'($urandom);
            jump_reg      = ($urandom_range(5) == 0);
            reg_target    = $urandom;
            if ($urandom_range(15) != 0) reg_target[1:0] = 2'b00;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
